// File: rtl/fb_pkg.sv
// Framebuffer geometry and pixel types shared by draw_line, the write buffer and the VGA reader.
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int FB_ADDR_W = 15;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } fb_xy_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fb_write_buffer.sv
// Clips draw_line pixels, linearises them and queues SRAM writes gated by grant.
// Optional FB_WRITE_BUFFER_CLIP_CNT_EN adds a saturating clip_count output.
module fb_write_buffer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = fb_pkg::FB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_valid,
  input  logic [X_W-1:0]            pix_x,
  input  logic [Y_W-1:0]            pix_y,
  output logic                      pix_ready,
  input  logic                      sram_grant,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic                      sram_wdata,
  output logic                      clip_pulse,
`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
  output logic [15:0]               clip_count,
`endif
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int LW = $clog2(DEPTH) + 1;

  fb_xy_t            pix;
  logic              accept;
  logic              clip;
  logic              push;
  logic [ADDR_W-1:0] addr;

  assign pix = '{x: pix_x, y: pix_y};

  assign pix_ready = (level != LW'(DEPTH));
  assign accept    = pix_valid && pix_ready;
  assign clip      = (int'(pix.x) >= FB_WIDTH)
                  || (int'(pix.y) >= FB_HEIGHT);
  assign push      = accept && !clip;

  assign addr = ADDR_W'(pix.y) * ADDR_W'(FB_WIDTH)
              + ADDR_W'(pix.x);

  assign busy       = (level != '0);
  assign sram_we    = busy && sram_grant;
  assign sram_wdata = 1'b1;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (sram_we),
    .wdata (addr),
    .rdata (sram_addr),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_pulse <= 1'b0;
    else        clip_pulse <= accept && clip;
  end

`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_count <= '0;
    else if (accept && clip && clip_count != 16'hFFFF)
      clip_count <= clip_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_write_buffer.sv
// Randomised and directed bench for fb_write_buffer with a queue-based reference model.
module tb_fb_write_buffer;

  logic        clk_tb = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic        pix_ready;
  logic        sram_grant;
  logic        sram_we;
  logic [14:0] sram_addr;
  logic        sram_wdata;
  logic        clip_pulse;
  logic        busy;
  logic [4:0]  level;
`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
  logic [15:0] clip_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  int mq[$];
  int wr_log[$];
  bit clip_exp = 1'b0;
  int clip_cnt_m = 0;
  int clip_seen = 0;

  always #5 clk_tb = ~clk_tb;

  fb_write_buffer dut (
    .clk        (clk_tb),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_ready  (pix_ready),
    .sram_grant (sram_grant),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .clip_pulse (clip_pulse),
`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
    .clip_count (clip_count),
`endif
    .busy       (busy),
    .level      (level)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: a queue of pending addresses evaluated between edges.
  always @(negedge clk_tb) begin
    bit exp_we, acc, clp;
    if (!rst_n) begin
      chk("rst_we", sram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", pix_ready, 1);
      chk("rst_clip", clip_pulse, 0);
      mq.delete();
      clip_exp = 1'b0;
      clip_cnt_m = 0;
    end else begin
      exp_we = (mq.size() != 0) && sram_grant;
      chk("ready", pix_ready, int'(mq.size() != 16));
      chk("level", level, mq.size());
      chk("busy", busy, int'(mq.size() != 0));
      chk("we", sram_we, int'(exp_we));
      chk("clip_pulse", clip_pulse, int'(clip_exp));
`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
      chk("clip_count", clip_count, clip_cnt_m);
`endif
      if (exp_we) begin
        chk("addr", sram_addr, mq[0]);
        chk("wdata", sram_wdata, 1);
      end
      if (sram_we) wr_log.push_back(int'(sram_addr));
      if (clip_pulse) clip_seen++;
      acc = pix_valid && (mq.size() != 16);
      clp = acc && (pix_x >= 160 || pix_y >= 120);
      if (exp_we) void'(mq.pop_front());
      if (acc && !clp) mq.push_back(int'(pix_y) * 160 + int'(pix_x));
      clip_exp = clp;
      if (clp && clip_cnt_m < 65535) clip_cnt_m++;
    end
  end

  task automatic send(input int x, input int y);
    bit ok = 1'b0;
    pix_x = 8'(x);
    pix_y = 7'(y);
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_tb);
      if (pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk_tb);
    #1 pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_tb);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk_tb);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix_x = 8'd1;
    pix_y = 7'd1;
    sram_grant = 1'b1;
    cycles(3);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    cycles(2);
    chk("no_store_in_reset", wr_log.size(), 0);

    // single pixel
    wr_log.delete();
    send(5, 3);
    wait_idle();
    chk("single_cnt", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("single_addr", wr_log[0], 485);

    // clipping
    wr_log.delete();
    clip_seen = 0;
    send(160, 0);
    send(0, 120);
    send(159, 119);
    wait_idle();
    cycles(2);
    chk("clip_pulses", clip_seen, 2);
    chk("clip_wr_cnt", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("clip_addr", wr_log[0], 19199);
`ifdef FB_WRITE_BUFFER_CLIP_CNT_EN
    chk("clip_count2", clip_count, 2);
`endif

    // full / backpressure
    wr_log.delete();
    sram_grant = 1'b0;
    for (int i = 0; i < 16; i++) send(i, 0);
    @(negedge clk_tb);
    chk("full_ready", pix_ready, 0);
    @(posedge clk_tb);
    #1;
    fork
      send(16, 0);
      begin
        cycles(4);
        sram_grant = 1'b1;
      end
    join
    wait_idle();
    chk("full_wr_cnt", wr_log.size(), 17);
    for (int i = 0; i < wr_log.size(); i++) chk("full_order", wr_log[i], i);

    // simultaneous push/pop at level 8
    wr_log.delete();
    sram_grant = 1'b0;
    for (int i = 0; i < 8; i++) send(i, 10);
    sram_grant = 1'b1;
    for (int i = 0; i < 10; i++) send(20 + i, 11);
    @(negedge clk_tb);
    chk("sim_level", level, 8);
    chk("sim_wr_cnt", wr_log.size(), 10);
    wait_idle();
    for (int i = 0; i < 18; i++)
      chk("sim_order", wr_log[i],
          (i < 8) ? 1600 + i : 1760 + 20 + (i - 8));

    // reset mid-drain
    sram_grant = 1'b0;
    for (int i = 0; i < 5; i++) send(i, 50);
    wr_log.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_busy_now", busy, 0);
    chk("rst_we_now", sram_we, 0);
    cycles(2);
    rst_n = 1'b1;
    sram_grant = 1'b1;
    cycles(5);
    chk("rst_no_write", wr_log.size(), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_x = 8'($urandom_range(0, 170));
      pix_y = 7'($urandom_range(0, 127));
      sram_grant = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    pix_valid = 1'b0;
    sram_grant = 1'b1;
    wait_idle();
    chk("final_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
